mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sits directly downstream of the request unit.
- Consumes the instruction-read and data-read/write strobes from the request unit and datapath, and arbitrates them onto the single-ported RAM.
- Returns per-port wait/load responses.
- Data access has priority. A bounded starvation counter guarantees instruction fetch progress.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data word width
STARVE_MAX, 4, consecutive data grants allowed while iREN is pending before an instruction grant is forced (>=1)

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  asynchronous active-low reset
iREN  in  1  instruction read request (from request unit imemren)
iaddr  in  ADDR_W  instruction address
dREN  in  1  data read request (request unit dmemren)
dWEN  in  1  data write request (request unit dmemwen)
daddr  in  ADDR_W  data address
dstore  in  DATA_W  write data
iwait  out  1  0 = instruction access complete this cycle
dwait  out  1  0 = data access complete this cycle
iload  out  DATA_W  registered instruction word
dload  out  DATA_W  registered data read word
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  ADDR_W  RAM address
ramstore  out  DATA_W  RAM write data
ramload  in  DATA_W  RAM read data
ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS (done), 3 ERROR
err  out  1  sticky: some access ended in ERROR

Behaviour:
Reset and clocking:
- One clock CLK. Asynchronous active-low reset nRST.
- Reset (async, any time incl. mid-access):
  - state=IDLE; ram strobes=0; ramaddr/ramstore=0; iload/dload=0.
  - starve count=0; err=0; iwait=dwait=1.
  - Any in-flight access is abandoned; no done pulse is produced.

FSM states: IDLE, IACC, DACC, IDONE, DDONE.
- IDLE:
  - Grant data if (dREN|dWEN) and not (iREN and cnt==STARVE_MAX) -> DACC.
  - Else if iREN -> IACC.
  - Else stay in IDLE.
  - At grant, latch addr, store data, and op (read/write) into internal registers.
  - dREN and dWEN both high: treated as write (dWEN wins).
- IACC/DACC:
  - Drive ramaddr/ramstore/ramREN/ramWEN from the latched registers only; inputs may change freely.
  - ramstate FREE/BUSY: hold.
  - ramstate ACCESS: capture ramload into iload (IACC) or dload (DACC, read only; write leaves dload unchanged), then go to IDONE/DDONE.
  - ramstate ERROR: load register <= 0, err <= 1, then go to IDONE/DDONE.
- IDONE/DDONE:
  - Strobes 0. iwait=0 (IDONE) or dwait=0 (DDONE) for exactly one cycle, then -> IDLE.
  - The done pulse occurs even if the request dropped mid-access; the requester ignores it.
- iwait = ~(state==IDONE); dwait = ~(state==DDONE). Both are combinational from state only.
- Latency: request visible in IDLE at cycle 0 -> ACC at cycle 1. If ACCESS is seen at cycle k, the done pulse is at cycle k+1. Minimum 3 cycles per access with a zero-wait RAM. Back-to-back accesses are separated by one IDLE cycle.
- Starvation counter cnt (width clog2(STARVE_MAX+1)):
  - On a data grant while iREN=1: cnt++, saturating at STARVE_MAX.
  - On an instruction grant or any IDLE cycle with iREN=0: cnt=0.
- err clears only on reset.

Test Plan:
1. Reset then iREN=1, iaddr=0x40, RAM returns ACCESS in the first IACC cycle with ramload=0x8C010004 -> ramREN=1/ramaddr=0x40 at cycle 1; iwait=0, iload=0x8C010004 at cycle 2; IDLE at cycle 3.
2. iREN=1 and dREN=1 simultaneously, daddr=0x100 -> data granted first (ramaddr=0x100); dwait pulses; then instruction granted; iwait pulses.
3. iREN held, dWEN asserted continuously, STARVE_MAX=4 -> exactly 4 data writes, then one instruction read, then cnt restarts at 0.
4. dWEN=1, dstore=0xDEADBEEF, ramstate BUSY for 3 cycles then ACCESS -> ramWEN/ramstore stable for 4 cycles; dwait low for exactly 1 cycle; dload unchanged.
5. ramstate=ERROR during IACC -> iload=0, err=1 and stays 1 through later good accesses.
6. nRST pulsed low during DACC -> all outputs at reset values immediately; no dwait pulse; next request served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction reads and data reads/writes onto a single-ported RAM.
// Data accesses win by default. A saturating starvation counter forces an instruction
// grant after STARVE_MAX data grants made while an instruction fetch was waiting.
//
// Ports:
//   CLK, nRST              clock (rising edge) and asynchronous active-low reset
//   iREN, iaddr            instruction read request and address
//   dREN, dWEN             data read and data write requests (write wins if both are high)
//   daddr, dstore          data address and write data
//   iwait, dwait           low for exactly one cycle when the port's access completes
//   iload, dload           registered read data for each port
//   ramREN, ramWEN         RAM read and write strobes
//   ramaddr, ramstore      RAM address and write data, driven from latched registers
//   ramload, ramstate      RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   err                    sticky flag: some access ended in ERROR
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic              iwait,
   output logic              dwait,
   output logic [DATA_W-1:0] iload,
   output logic [DATA_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   input  logic [DATA_W-1:0] ramload,
   input  logic [1:0]        ramstate,
   output logic              err
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic [1:0] RAM_ERROR  = 2'd3;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      IACC  = 3'd1,
      DACC  = 3'd2,
      IDONE = 3'd3,
      DDONE = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] store_q, store_d;
   logic              wr_q, wr_d;
   logic [DATA_W-1:0] iload_q, iload_d;
   logic [DATA_W-1:0] dload_q, dload_d;
   logic              err_q, err_d;

   logic              d_req_s;
   logic              starved_s;

   assign d_req_s   = dREN | dWEN;
   assign starved_s = iREN & (cnt_q == CNT_MAX);

   // State, latched request and response registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         addr_q  <= {ADDR_W{1'b0}};
         store_q <= {DATA_W{1'b0}};
         wr_q    <= 1'b0;
         iload_q <= {DATA_W{1'b0}};
         dload_q <= {DATA_W{1'b0}};
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         store_q <= store_d;
         wr_q    <= wr_d;
         iload_q <= iload_d;
         dload_q <= dload_d;
         err_q   <= err_d;
      end
   end

   // Next-state, grant and load-capture logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      store_d = store_q;
      wr_d    = wr_q;
      iload_d = iload_q;
      dload_d = dload_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (d_req_s && !starved_s) begin
               state_d = DACC;
               addr_d  = daddr;
               store_d = dstore;
               wr_d    = dWEN;
               // Count only grants that made a pending fetch wait; saturate at the limit.
               if (!iREN) begin
                  cnt_d = {CNT_W{1'b0}};
               end else if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
               end else begin
                  cnt_d = cnt_q;
               end
            end else if (iREN) begin
               state_d = IACC;
               addr_d  = iaddr;
               wr_d    = 1'b0;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               state_d = IDLE;
               cnt_d   = {CNT_W{1'b0}};
            end
         end
         IACC: begin
            if (ramstate == RAM_ACCESS) begin
               iload_d = ramload;
               state_d = IDONE;
            end else if (ramstate == RAM_ERROR) begin
               iload_d = {DATA_W{1'b0}};
               err_d   = 1'b1;
               state_d = IDONE;
            end else begin
               state_d = IACC;
            end
         end
         DACC: begin
            if (ramstate == RAM_ACCESS) begin
               // A completed write leaves the previous read data in place.
               if (!wr_q) begin
                  dload_d = ramload;
               end else begin
                  dload_d = dload_q;
               end
               state_d = DDONE;
            end else if (ramstate == RAM_ERROR) begin
               dload_d = {DATA_W{1'b0}};
               err_d   = 1'b1;
               state_d = DDONE;
            end else begin
               state_d = DACC;
            end
         end
         IDONE:   state_d = IDLE;
         DDONE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // RAM side is driven only from latched registers so requesters may change inputs mid-access.
   assign ramREN   = (state_q == IACC) | ((state_q == DACC) & ~wr_q);
   assign ramWEN   = (state_q == DACC) & wr_q;
   assign ramaddr  = addr_q;
   assign ramstore = store_q;

   assign iwait = ~(state_q == IDONE);
   assign dwait = ~(state_q == DDONE);
   assign iload = iload_q;
   assign dload = dload_q;
   assign err   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (STARVE_MAX = 4).
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   localparam logic [1:0] R_FREE   = 2'd0;
   localparam logic [1:0] R_BUSY   = 2'd1;
   localparam logic [1:0] R_ACCESS = 2'd2;
   localparam logic [1:0] R_ERROR  = 2'd3;

   logic          CLK = 1'b0;
   logic          nRST = 1'b0;
   logic          iREN = 1'b0;
   logic [AW-1:0] iaddr = '0;
   logic          dREN = 1'b0;
   logic          dWEN = 1'b0;
   logic [AW-1:0] daddr = '0;
   logic [DW-1:0] dstore = '0;
   logic          iwait, dwait;
   logic [DW-1:0] iload, dload;
   logic          ramREN, ramWEN;
   logic [AW-1:0] ramaddr;
   logic [DW-1:0] ramstore;
   logic [DW-1:0] ramload = '0;
   logic [1:0]    ramstate;
   logic          err;

   // auto_mode: zero-wait RAM that answers ACCESS whenever a strobe is up.
   logic          auto_mode = 1'b0;
   logic [1:0]    ram_manual = 2'd0;

   int n_checks = 0;
   int n_errors = 0;

   assign ramstate = auto_mode ? ((ramREN | ramWEN) ? R_ACCESS : R_FREE) : ram_manual;

   always #5 CLK = ~CLK;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .err(err)
   );

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      int writes;
      int found;

      // Reset
      #12;
      check_val("rst_ramREN", ramREN, 1'b0);
      check_val("rst_ramWEN", ramWEN, 1'b0);
      check_val("rst_ramaddr", ramaddr, 32'h0);
      check_val("rst_iwait", iwait, 1'b1);
      check_val("rst_dwait", dwait, 1'b1);
      check_val("rst_err", err, 1'b0);
      nRST = 1'b1;
      tick();

      // 1: single instruction read, zero-wait RAM
      iREN = 1'b1; iaddr = 32'h40;
      tick();
      check_val("t1_ramREN", ramREN, 1'b1);
      check_val("t1_ramaddr", ramaddr, 32'h40);
      check_val("t1_iwait_acc", iwait, 1'b1);
      ram_manual = R_ACCESS; ramload = 32'h8C010004;
      tick();
      iREN = 1'b0; ram_manual = R_FREE;
      check_val("t1_iwait", iwait, 1'b0);
      check_val("t1_iload", iload, 32'h8C010004);
      check_val("t1_ramREN_done", ramREN, 1'b0);
      tick();
      check_val("t1_iwait_idle", iwait, 1'b1);
      check_val("t1_ramREN_idle", ramREN, 1'b0);

      // 2: simultaneous requests, data first
      auto_mode = 1'b1;
      iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h100; ramload = 32'h1234;
      tick();
      check_val("t2_d_ramaddr", ramaddr, 32'h100);
      check_val("t2_d_ramREN", ramREN, 1'b1);
      dREN = 1'b0;
      tick();
      check_val("t2_dwait", dwait, 1'b0);
      check_val("t2_dload", dload, 32'h1234);
      check_val("t2_iwait_hi", iwait, 1'b1);
      tick();
      ramload = 32'h5678;
      tick();
      check_val("t2_i_ramaddr", ramaddr, 32'h80);
      check_val("t2_i_ramREN", ramREN, 1'b1);
      iREN = 1'b0;
      tick();
      check_val("t2_iwait", iwait, 1'b0);
      check_val("t2_iload", iload, 32'h5678);
      tick();

      // 3: starvation bound, then counter restarts
      iREN = 1'b1; iaddr = 32'hC0; dWEN = 1'b1; daddr = 32'h300; dstore = 32'hA5A5;
      writes = 0; found = 0;
      for (int c = 0; c < 60 && found == 0; c++) begin
         if (ramWEN) writes++;
         if (ramREN) found = 1;
         if (found == 0) tick();
      end
      check_val("t3_first_iacc_seen", found, 1);
      check_val("t3_writes_before_i", writes, 4);
      check_val("t3_i_ramaddr", ramaddr, 32'hC0);
      tick();
      writes = 0; found = 0;
      for (int c = 0; c < 60 && found == 0; c++) begin
         if (ramWEN) writes++;
         if (ramREN) found = 1;
         if (found == 0) tick();
      end
      check_val("t3_second_iacc_seen", found, 1);
      check_val("t3_writes_after_restart", writes, 4);
      iREN = 1'b0; dWEN = 1'b0;
      tick();
      tick();
      auto_mode = 1'b0; ram_manual = R_FREE;

      // 4: write with 3 BUSY cycles then ACCESS
      dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF; ram_manual = R_BUSY;
      tick();
      dWEN = 1'b0; dstore = 32'h0; daddr = 32'h0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) ram_manual = R_ACCESS;
         check_val("t4_ramWEN", ramWEN, 1'b1);
         check_val("t4_ramstore", ramstore, 32'hDEADBEEF);
         check_val("t4_ramaddr", ramaddr, 32'h200);
         check_val("t4_dwait_acc", dwait, 1'b1);
         tick();
      end
      ram_manual = R_FREE;
      check_val("t4_dwait", dwait, 1'b0);
      check_val("t4_dload_kept", dload, 32'h1234);
      check_val("t4_ramWEN_done", ramWEN, 1'b0);
      tick();
      check_val("t4_dwait_after", dwait, 1'b1);

      // 5: ERROR during IACC, err sticky
      iREN = 1'b1; iaddr = 32'h44;
      tick();
      ram_manual = R_ERROR; iREN = 1'b0;
      tick();
      ram_manual = R_FREE;
      check_val("t5_iwait", iwait, 1'b0);
      check_val("t5_iload", iload, 32'h0);
      check_val("t5_err", err, 1'b1);
      tick();
      auto_mode = 1'b1; dREN = 1'b1; daddr = 32'h10; ramload = 32'h55;
      tick();
      dREN = 1'b0;
      tick();
      check_val("t5_dload_good", dload, 32'h55);
      check_val("t5_err_sticky", err, 1'b1);
      tick();
      auto_mode = 1'b0;

      // 6: reset during DACC
      ram_manual = R_BUSY; dREN = 1'b1; daddr = 32'h88;
      tick();
      check_val("t6_ramREN_pre", ramREN, 1'b1);
      dREN = 1'b0;
      #2 nRST = 1'b0;
      #1;
      check_val("t6_ramREN", ramREN, 1'b0);
      check_val("t6_ramaddr", ramaddr, 32'h0);
      check_val("t6_dwait", dwait, 1'b1);
      check_val("t6_iload", iload, 32'h0);
      check_val("t6_dload", dload, 32'h0);
      check_val("t6_err", err, 1'b0);
      nRST = 1'b1;
      ram_manual = R_FREE;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("t6_no_dwait", dwait, 1'b1);
      end
      auto_mode = 1'b1; dREN = 1'b1; daddr = 32'h90; ramload = 32'h77;
      tick();
      check_val("t6_re_ramaddr", ramaddr, 32'h90);
      dREN = 1'b0;
      tick();
      check_val("t6_re_dwait", dwait, 1'b0);
      check_val("t6_re_dload", dload, 32'h77);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
